// File: rtl/sevseg_timer_mux_pkg.sv
// Shared types, segment constants and BCD-to-7-segment decode
// for the multiplexed BCD timer.
package sevseg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // {g,f,e,d,c,b,a}, active-high
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    function automatic seg_t seg_decode(input bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevseg_timer_mux_if.sv
// Control and display bundle between the TT top wrapper
// (master) and the timer/mux block (slave).
interface sevseg_timer_mux_if
    import sevseg_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                  ena;
    logic                  run;
    logic                  down;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    seg_t                  segments;
    logic [DIGITS-1:0]     digit_sel;
    logic                  tick;
    logic                  wrap;

    modport master (
        output ena, run, down, clear, load, load_val,
        input  bcd, segments, digit_sel, tick, wrap
    );

    modport slave (
        input  ena, run, down, clear, load, load_val,
        output bcd, segments, digit_sel, tick, wrap
    );

endinterface

// File: rtl/sevseg_timer_mux_bcd_digit.sv
// One BCD digit of the ripple up/down counter; carry/borrow
// are combinational so a whole chain steps on a single edge.
module sevseg_bcd_digit
    import sevseg_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic down,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (ld) begin
            q_d = (ld_val > 4'd9) ? 4'd9 : ld_val;
        end else if (en) begin
            if (down) q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
            else      q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q      = q_q;
    assign carry  = en & ~down & (q_q == 4'd9);
    assign borrow = en &  down & (q_q == 4'd0);

endmodule

// File: rtl/sevseg_timer_mux.sv
// N-digit BCD up/down timer with multiplexed 7-seg driver.
// Define SEVSEG_LEADING_BLANK_EN to blank leading zero digits.
module sevseg_timer_mux
    import sevseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10_000_000,
    parameter int MUX_DIV  = 10_000
)(
    input  logic clk,
    input  logic rst_n,
    sevseg_timer_mux_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] REF_TC = MW'(MUX_DIV - 1);
    localparam logic [IW-1:0] IDX_TC = IW'(DIGITS - 1);

    logic [PW-1:0]       pre_q, pre_d;
    logic [MW-1:0]       ref_q, ref_d;
    logic [IW-1:0]       idx_q, idx_d;
    seg_t                seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                tick_q, wrap_q;

    logic                do_clr, do_ld, step;
    bcd_t                dig_q [DIGITS];
    logic [DIGITS-1:0]   dig_en, carry, borrow;
    logic [4*DIGITS-1:0] bcd_w;
    bcd_t                cur;
    logic                blank;

    assign do_clr = bus.ena & bus.clear;
    assign do_ld  = bus.ena & bus.load & ~bus.clear;
    assign step   = bus.ena & bus.run & (pre_q == PRE_TC)
                  & ~bus.clear & ~bus.load;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            assign dig_en[i] = step;
        end else begin : g_rip
            assign dig_en[i] = carry[i-1] | borrow[i-1];
        end

        sevseg_bcd_digit u_dig (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (dig_en[i]),
            .down   (bus.down),
            .clr    (do_clr),
            .ld     (do_ld),
            .ld_val (bus.load_val[4*i +: 4]),
            .q      (dig_q[i]),
            .carry  (carry[i]),
            .borrow (borrow[i])
        );

        assign bcd_w[4*i +: 4] = dig_q[i];
    end

    always_comb begin
        pre_d = pre_q;
        ref_d = ref_q;
        idx_d = idx_q;
        if (do_clr || do_ld) begin
            pre_d = '0;
        end else if (bus.ena && bus.run) begin
            pre_d = (pre_q == PRE_TC) ? '0 : pre_q + 1'b1;
        end
        if (bus.ena) begin
            if (ref_q == REF_TC) begin
                ref_d = '0;
                idx_d = (idx_q == IDX_TC) ? '0 : idx_q + 1'b1;
            end else begin
                ref_d = ref_q + 1'b1;
            end
        end
    end

`ifdef SEVSEG_LEADING_BLANK_EN
    logic lead_zero;

    // Walk down from the MSD; digit 0 is never considered.
    always_comb begin
        lead_zero = 1'b1;
        blank     = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero & (dig_q[i] == 4'd0);
            if (IW'(i) == idx_q) blank = lead_zero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cur   = dig_q[idx_q];
        sel_d = '0;
        seg_d = SEG_BLANK;
        if (bus.ena) begin
            sel_d[idx_q] = 1'b1;
            seg_d        = blank ? SEG_BLANK : seg_decode(cur);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            ref_q  <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            sel_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            tick_q <= step;
            wrap_q <= carry[DIGITS-1] | borrow[DIGITS-1];
        end
    end

    assign bus.bcd       = bcd_w;
    assign bus.segments  = seg_q;
    assign bus.digit_sel = sel_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_sevseg_timer_mux.sv
// Bench for sevseg_timer_mux: decimal-arithmetic reference model,
// load/decode vector table and directed corner sequences.
module tb_sevseg_timer_mux;

    localparam int D  = 2;
    localparam int TD = 4;
    localparam int MD = 2;
    localparam int MAXC = 99;

    localparam logic [6:0] SEGT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

`ifdef SEVSEG_LEADING_BLANK_EN
    localparam logic [6:0] LEAD0_SEG = 7'h00;
`else
    localparam logic [6:0] LEAD0_SEG = 7'h3F;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevseg_timer_mux_if #(.DIGITS(D)) bus ();

    sevseg_timer_mux #(
        .DIGITS   (D),
        .TICK_DIV (TD),
        .MUX_DIV  (MD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    int         m_cnt, m_pre, m_rf, m_idx;
    bit         m_tick, m_wrap;
    logic [6:0] m_seg;
    logic [D-1:0] m_sel;

    typedef struct {
        logic [7:0] lv;
        logic [7:0] exp_bcd;
        logic [6:0] exp_seg0;
    } vec_t;
    vec_t vt [6];

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [7:0] lv);
        int v = 0;
        int n;
        for (int i = 0; i < D; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v += n * pow10(i);
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_rf = 0; m_idx = 0;
        m_tick = 0; m_wrap = 0; m_seg = '0; m_sel = '0;
    endtask

    // One clock: predict from current inputs, advance, compare.
    task automatic cyc();
        int ncnt, npre, nrf, nidx, dg;
        bit nt, nw;
        logic [6:0] nseg;
        logic [D-1:0] nsel;
        ncnt = m_cnt; npre = m_pre; nrf = m_rf; nidx = m_idx;
        nt = 0; nw = 0; nseg = '0; nsel = '0;
        if (bus.ena) begin
            dg = (m_cnt / pow10(m_idx)) % 10;
            nsel[m_idx] = 1'b1;
            nseg = SEGT[dg];
`ifdef SEVSEG_LEADING_BLANK_EN
            if (m_idx > 0 && m_cnt < pow10(m_idx)) nseg = '0;
`endif
            if (bus.clear) begin
                ncnt = 0; npre = 0;
            end else if (bus.load) begin
                ncnt = clamp_val(bus.load_val); npre = 0;
            end else if (bus.run) begin
                if (m_pre == TD - 1) begin
                    npre = 0; nt = 1;
                    if (bus.down) begin
                        if (m_cnt == 0) begin ncnt = MAXC; nw = 1; end
                        else ncnt = m_cnt - 1;
                    end else begin
                        if (m_cnt == MAXC) begin ncnt = 0; nw = 1; end
                        else ncnt = m_cnt + 1;
                    end
                end else begin
                    npre = m_pre + 1;
                end
            end
            if (m_rf == MD - 1) begin
                nrf = 0; nidx = (m_idx + 1) % D;
            end else begin
                nrf = m_rf + 1;
            end
        end
        @(posedge clk);
        #1;
        m_cnt = ncnt; m_pre = npre; m_rf = nrf; m_idx = nidx;
        m_tick = nt; m_wrap = nw; m_seg = nseg; m_sel = nsel;
        chk("model bcd", bus.bcd, to_bcd(m_cnt));
        chk("model tick", bus.tick, m_tick);
        chk("model wrap", bus.wrap, m_wrap);
        chk("model segments", bus.segments, m_seg);
        chk("model digit_sel", bus.digit_sel, m_sel);
    endtask

    task automatic wait_tick(input string nm);
        bit f = 0;
        for (int k = 0; k < 2 * TD && !f; k++) begin
            cyc();
            f = bus.tick;
        end
        chk(nm, f, 1);
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load = 1'b1;
        bus.load_val = v;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic wait_sel(input string nm, input logic [D-1:0] s);
        for (int k = 0; k < 2 * MD * D && bus.digit_sel != s; k++) cyc();
        chk(nm, bus.digit_sel, s);
    endtask

    task automatic align_term();
        for (int k = 0; k < TD && m_pre != TD - 1; k++) cyc();
        chk("prescaler align", m_pre, TD - 1);
    endtask

    initial begin
        int ticks, last, n, runlen;
        logic [D-1:0] psel;

        vt[0] = '{8'hA5, 8'h95, 7'h6D};
        vt[1] = '{8'h37, 8'h37, 7'h07};
        vt[2] = '{8'hFF, 8'h99, 7'h6F};
        vt[3] = '{8'h9A, 8'h99, 7'h6F};
        vt[4] = '{8'h08, 8'h08, 7'h7F};
        vt[5] = '{8'h61, 8'h61, 7'h06};

        bus.ena = 0; bus.run = 0; bus.down = 0;
        bus.clear = 0; bus.load = 0; bus.load_val = '0;
        model_reset();
        #12;
        chk("reset bcd", bus.bcd, 0);
        chk("reset segments", bus.segments, 0);
        chk("reset digit_sel", bus.digit_sel, 0);
        chk("reset tick", bus.tick, 0);
        chk("reset wrap", bus.wrap, 0);
        rst_n = 1'b1;

        // basic count
        bus.ena = 1; bus.run = 1;
        ticks = 0; last = -1;
        for (n = 0; n < 40; n++) begin
            cyc();
            if (bus.tick) begin
                if (last >= 0) chk("tick period", n - last, TD);
                last = n;
                ticks++;
            end
        end
        chk("basic tick count", ticks, 10);
        chk("basic bcd", bus.bcd, 8'h10);

        // up wrap
        bus.run = 0;
        do_load(8'h99);
        chk("load 99", bus.bcd, 8'h99);
        bus.run = 1;
        wait_tick("up wrap tick");
        chk("up wrap bcd", bus.bcd, 8'h00);
        chk("up wrap pulse", bus.wrap, 1);
        cyc();
        chk("up wrap tick one-shot", bus.tick, 0);
        chk("up wrap one-shot", bus.wrap, 0);

        // down wrap then direction change
        bus.down = 1;
        wait_tick("down wrap tick");
        chk("down wrap bcd", bus.bcd, 8'h99);
        chk("down wrap pulse", bus.wrap, 1);
        bus.down = 0;
        wait_tick("dir change tick");
        chk("dir change bcd", bus.bcd, 8'h00);

        // priority at terminal count
        bus.run = 0;
        do_load(8'h55);
        bus.run = 1;
        align_term();
        bus.clear = 1; bus.load = 1; bus.load_val = 8'h37;
        cyc();
        bus.clear = 0; bus.load = 0;
        chk("clear wins bcd", bus.bcd, 8'h00);
        chk("clear no tick", bus.tick, 0);
        align_term();
        do_load(8'h37);
        chk("load at tc bcd", bus.bcd, 8'h37);
        chk("load no tick", bus.tick, 0);

        // load clamp and decode vectors
        bus.run = 0;
        foreach (vt[i]) begin
            do_load(vt[i].lv);
            chk($sformatf("vec%0d bcd", i), bus.bcd, vt[i].exp_bcd);
            cyc();
            wait_sel($sformatf("vec%0d sel", i), 2'b01);
            chk($sformatf("vec%0d seg0", i), bus.segments, vt[i].exp_seg0);
        end

        // mux alternation
        do_load(8'h42);
        cyc();
        psel = bus.digit_sel;
        runlen = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (bus.digit_sel == 2'b01) chk("mux seg d0", bus.segments, 7'h5B);
            else chk("mux seg d1", bus.segments, 7'h66);
            runlen++;
            if (bus.digit_sel != psel) begin
                if (k > 1) chk("mux dwell", runlen, MD);
                runlen = 0;
                psel = bus.digit_sel;
            end
        end

        // ena low: blank, hold
        bus.ena = 0; bus.run = 1;
        repeat (5) cyc();
        chk("ena0 segments", bus.segments, 0);
        chk("ena0 digit_sel", bus.digit_sel, 0);
        chk("ena0 bcd held", bus.bcd, 8'h42);
        bus.ena = 1; bus.run = 0;
        repeat (3) cyc();

        // leading blank
        do_load(8'h07);
        cyc();
        wait_sel("blank sel", 2'b10);
        chk("lead zero digit1", bus.segments, LEAD0_SEG);
        do_load(8'h00);
        cyc();
        wait_sel("zero sel", 2'b01);
        chk("digit0 never blank", bus.segments, 7'h3F);

        // reset mid-count
        bus.run = 1;
        do_load(8'h28);
        repeat (6) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset bcd", bus.bcd, 0);
        chk("midreset segments", bus.segments, 0);
        chk("midreset digit_sel", bus.digit_sel, 0);
        chk("midreset tick", bus.tick, 0);
        chk("midreset wrap", bus.wrap, 0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (8) cyc();

        // random
        for (int k = 0; k < 500; k++) begin
            bus.ena      = ($urandom_range(0, 9) != 0);
            bus.run      = ($urandom_range(0, 3) != 0);
            bus.down     = ($urandom_range(0, 1) != 0);
            bus.clear    = ($urandom_range(0, 29) == 0);
            bus.load     = ($urandom_range(0, 14) == 0);
            bus.load_val = 8'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevseg_timer_mux.md
# sevseg_timer_mux

Parametrised N-digit BCD up/down timer with a time-multiplexed seven-segment driver: the successor to the single-digit seconds counter in the Tiny Tapeout top. It replaces the hard-wired one-digit, count-up-only display with configurable digit count, tick rate and refresh rate, and adds run/stop, direction, clear and load. It sits between the `tt_um_*` top (which maps `ui_in` and `uo_out`/`uio_out`) and the display pins.

## Interface
- `DIGITS`, default 4: number of BCD digits. Legal range 1..8.
- `TICK_DIV`, default 10_000_000: `clk` cycles per count tick. Must be ≥ 2.
- `MUX_DIV`, default 10_000: `clk` cycles per digit-refresh step. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  design selected. When low, all state holds and the display outputs are blanked.
- `run`  in  1  when high, the prescaler advances.
- `down`  in  1  count direction: 1 = decrement, 0 = increment.
- `clear`  in  1  synchronous clear of the counter and the prescaler.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4*DIGITS  BCD load value. Digit 0 is in [3:0].
- `bcd`  out  4*DIGITS  current count.
- `segments`  out  7  {g,f,e,d,c,b,a}, active-high.
- `digit_sel`  out  DIGITS  one-hot active-high enable for the digit being driven.
- `tick`  out  1  one-cycle pulse per count step.
- `wrap`  out  1  one-cycle pulse when the count wraps.

## Operation
- **Prescaler.** Counts 0..TICK_DIV-1, but only while `ena & run`. At TICK_DIV-1 it returns to 0 and the counter steps once.
- **Count up.** Ripple BCD increment. 99..9 wraps to 00..0 and pulses `wrap`.
- **Count down.** 00..0 wraps to 99..9 and pulses `wrap`.
- **Priority.** `clear` > `load` > step.
  - `clear` zeroes `bcd` and the prescaler.
  - `load` copies `load_val` into `bcd`, clamping any nibble >9 to 9, and zeroes the prescaler.
  - Neither `clear` nor `load` pulses `tick` or `wrap`.
  - Both act only when `ena` is high. `run` does not gate them.
- **Mux.** A refresh counter (0..MUX_DIV-1) runs whenever `ena` is high. At its terminal count, the digit index advances 0→1→…→DIGITS-1→0.
- **Display outputs.**
  - `digit_sel` = one-hot of the index.
  - `segments` = decode of `bcd` nibble[index].
  - Decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - When `ena` is low, `segments`=0 and `digit_sel`=0, and the index is held.
- **Direction change.** Changing `down` mid-count takes effect at the next step. The prescaler is not reset.

## Timing
- **Reset values.** `bcd`=0, `segments`=0, `digit_sel`=0, `tick`=0, `wrap`=0. Prescaler, refresh counter and index are all 0.
- **Step latency.** On the edge where the prescaler is at TICK_DIV-1, `bcd` updates and `tick` is registered. `tick` and the new `bcd` are therefore visible in the same following cycle. `wrap` coincides with `tick`.
- **Tick period.** With `run` held high, `tick` period is exactly TICK_DIV cycles. There are no back-to-back ticks.
- **Display latency.** `segments` and `digit_sel` are registered and updated every active cycle from the current index and `bcd`. `segments` therefore lags `bcd` by one cycle. `digit_sel` and `segments` always change on the same edge.
- **Stop.** Deasserting `run` freezes the prescaler value. Reasserting `run` resumes from that value.
- **Clear or load at the terminal count.** If `clear` or `load` arrives in the cycle the prescaler is at its terminal count, `clear`/`load` wins and no `tick` is issued.
- **Reset mid-operation.** An asynchronous return to reset values. The first active update is on the first edge after `rst_n` rises.

## Configuration
- **`SEVSEG_LEADING_BLANK_EN` defined.**
  - A digit with index >0 is blanked (`segments`=0, `digit_sel` still asserted) if it and every more-significant digit are 0.
  - Digit 0 is never blanked.
- **Undefined.** All digits are decoded, leading zeros included. `bcd`, `tick` and `wrap` are unaffected either way.

## Structure
- **Package `sevseg_pkg`.**
  - Segment constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - Function `seg_decode(logic [3:0])`; nibbles >9 decode to blank.
  - Typedef `bcd_t` (4-bit).
- **Sub-module `sevseg_bcd_digit`.** One BCD digit with inputs `en`/`down`/`clr`/`ld`/`ld_val` and outputs `carry`/`borrow`. It is instantiated DIGITS times in a generate loop, with carry/borrow chained.
- The prescaler, refresh counter and output registers live in the top.

## Test plan
1. **Basic count.** DIGITS=2, TICK_DIV=4, `run`=1, `down`=0, 40 cycles after reset → `tick` every 4 cycles; `bcd` reaches 0x10 after the 10th tick.
2. **Up wrap.** `load` 0x99, then one tick → `bcd`=0x00 with `tick` and `wrap` high in the same cycle, for one cycle.
3. **Down wrap and direction change.** `down`=1 from 0x00 → 0x99 with `wrap`. Toggle to `down`=0 → next tick gives 0x00.
4. **Priority.**
   - `clear` and `load` (0x37) in the prescaler terminal cycle → `bcd`=0x00, no `tick`.
   - `load_val`=0xA5 → `bcd`=0x95.
5. **Mux.**
   - MUX_DIV=2, `bcd`=0x42 → `digit_sel` alternates 01/10 every 2 cycles, with `segments` 0x5B/0x66 respectively.
   - `ena`=0 → both outputs 0 and all state held.
6. **Blanking.** `bcd`=0x07 → digit 1 gives `segments`=0 with `SEVSEG_LEADING_BLANK_EN` defined, and 0x3F without it. Also assert reset mid-count → all outputs 0 immediately.
